// File: rtl/ocimem_pkg.sv
// Shared types and JTAG data-word field positions for the debug-memory controller.
package ocimem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    J_RD  = 2'd1,
    C_ACK = 2'd2
  } state_e;

  localparam int JDO_RD_BIT    = 34;
  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_WDATA_MSB = 34;
  localparam int JDO_WDATA_LSB = 3;

endpackage

// File: rtl/ocimem_ram.sv
// Single-port byte-enabled debug RAM, read-first, one-cycle registered read.
module ocimem_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/nios2_timer_debug_ocimem_ctrl.sv
// Executes JTAG debug-slave reads/writes into the debug RAM and arbitrates them
// against CPU Avalon-MM accesses; JTAG work wins whenever the FSM is idle.
//
// state | meaning
// IDLE  | accept pending JTAG write, JTAG read, or CPU access (that priority)
// J_RD  | RAM data for a JTAG read is on q; capture into MonDReg
// C_ACK | RAM data for a CPU access is on q; complete the Avalon transfer
module nios2_timer_debug_ocimem_ctrl
  import ocimem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [37:0]   jdo,
  input  logic          take_action_ocimem_a,
  input  logic          take_no_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  output logic [31:0]   MonDReg,
  output logic          monitor_ready,
  output logic          monitor_error,
  input  logic [AW-1:0] avs_address,
  input  logic          avs_read,
  input  logic          avs_write,
  input  logic [31:0]   avs_writedata,
  input  logic [3:0]    avs_byteenable,
  input  logic          avs_debugaccess,
  output logic [31:0]   avs_readdata,
  output logic          avs_waitrequest
);

  state_e        state_q, state_d;
  logic [AW-1:0] jaddr_q, jaddr_d;
  logic          pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d, inc_q, inc_d;
  logic [31:0]   jwdata_q, jwdata_d, mon_dreg_q, mon_dreg_d, avs_rdata_q, avs_rdata_d;
  logic          mon_ready_q, mon_ready_d, mon_error_q, mon_error_d;
  logic          strb_a, strb_n, strb_b, multi, rd_req;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wdata, ram_q;
  logic          unused_jdo;

  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  assign strb_a = take_action_ocimem_a;
  assign strb_n = take_no_action_ocimem_a & ~take_action_ocimem_a;
  assign strb_b = take_action_ocimem_b & ~take_action_ocimem_a & ~take_no_action_ocimem_a;
  assign multi  = (take_action_ocimem_a & take_no_action_ocimem_a) |
                  (take_action_ocimem_a & take_action_ocimem_b) |
                  (take_no_action_ocimem_a & take_action_ocimem_b);
  assign rd_req = (strb_a & jdo[JDO_RD_BIT]) | strb_n;

  always_comb begin
    state_d     = state_q;
    jaddr_d     = jaddr_q;
    pend_rd_d   = pend_rd_q;
    pend_wr_d   = pend_wr_q;
    inc_d       = inc_q;
    jwdata_d    = jwdata_q;
    mon_dreg_d  = mon_dreg_q;
    mon_ready_d = mon_ready_q;
    mon_error_d = mon_error_q;
    avs_rdata_d = avs_rdata_q;
    ram_addr    = jaddr_q;
    ram_we      = 1'b0;
    ram_be      = 4'hF;
    ram_wdata   = jwdata_q;

    case (state_q)
      IDLE: begin
        if (pend_wr_q) begin
          ram_we    = 1'b1;
          jaddr_d   = jaddr_q + AW'(1);
          pend_wr_d = 1'b0;
        end else if (pend_rd_q) begin
          state_d = J_RD;
        end else if (avs_read || avs_write) begin
          ram_addr  = avs_address;
          ram_we    = avs_write & avs_debugaccess;
          ram_be    = avs_byteenable;
          ram_wdata = avs_writedata;
          state_d   = C_ACK;
        end
      end
      J_RD: begin
        mon_dreg_d  = ram_q;
        mon_ready_d = 1'b1;
        if (inc_q) jaddr_d = jaddr_q + AW'(1);
        pend_rd_d   = 1'b0;
        state_d     = IDLE;
      end
      C_ACK: begin
        avs_rdata_d = ram_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A newly accepted command overrides whatever the FSM did to the same fields.
    if (strb_a) jaddr_d = jdo[JDO_ADDR_LSB +: AW];
    if (rd_req) begin
      pend_rd_d = 1'b1;
      inc_d     = strb_n;
      if (pend_rd_q) mon_error_d = 1'b1;
    end
    if (strb_b) begin
      pend_wr_d = 1'b1;
      jwdata_d  = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
      if (pend_wr_q) mon_error_d = 1'b1;
    end
    if (multi) mon_error_d = 1'b1;
    if (strb_a || strb_n || strb_b) mon_ready_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      jaddr_q     <= '0;
      pend_rd_q   <= 1'b0;
      pend_wr_q   <= 1'b0;
      inc_q       <= 1'b0;
      jwdata_q    <= '0;
      mon_dreg_q  <= '0;
      mon_ready_q <= 1'b0;
      mon_error_q <= 1'b0;
      avs_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      jaddr_q     <= jaddr_d;
      pend_rd_q   <= pend_rd_d;
      pend_wr_q   <= pend_wr_d;
      inc_q       <= inc_d;
      jwdata_q    <= jwdata_d;
      mon_dreg_q  <= mon_dreg_d;
      mon_ready_q <= mon_ready_d;
      mon_error_q <= mon_error_d;
      avs_rdata_q <= avs_rdata_d;
    end
  end

  ocimem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  // RAM data is already valid in the ack cycle; the register holds it afterwards.
  assign avs_readdata    = (state_q == C_ACK) ? ram_q : avs_rdata_q;
  assign avs_waitrequest = (avs_read | avs_write) & (state_q != C_ACK);
  assign MonDReg         = mon_dreg_q;
  assign monitor_ready   = mon_ready_q;
  assign monitor_error   = mon_error_q;

endmodule

// File: tb/tb_nios2_timer_debug_ocimem_ctrl.sv
// Scoreboarded bench for the debug-memory controller: JTAG and CPU paths.
module tb_nios2_timer_debug_ocimem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [37:0] jdo = '0;
  logic        take_a = 1'b0, take_n = 1'b0, take_b = 1'b0;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;
  logic [7:0]  avs_address = '0;
  logic        avs_read = 1'b0, avs_write = 1'b0, avs_debugaccess = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [3:0]  avs_byteenable = '0;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model [256];
  logic [31:0] jexp [$];
  logic [31:0] cexp [$];

  always #5 clk = ~clk;

  nios2_timer_debug_ocimem_ctrl #(.DEPTH(256), .AW(8)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_no_action_ocimem_a (take_n),
    .take_action_ocimem_b    (take_b),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_debugaccess         (avs_debugaccess),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  task automatic jtag_a(input logic [7:0] addr, input logic rd);
    jdo = '0; jdo[34] = rd; jdo[24:17] = addr;
    take_a = 1'b1; tick(); take_a = 1'b0;
  endtask

  task automatic jtag_b(input logic [31:0] d);
    jdo = '0; jdo[34:3] = d;
    take_b = 1'b1; tick(); take_b = 1'b0;
  endtask

  task automatic jtag_n();
    take_n = 1'b1; tick(); take_n = 1'b0;
  endtask

  task automatic wait_ready(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (monitor_ready) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic cpu_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input logic dbg,
                          output logic [31:0] rd, output int waits);
    avs_address = addr; avs_write = wr; avs_read = ~wr;
    avs_writedata = wd; avs_byteenable = be; avs_debugaccess = dbg;
    waits = 0; #1;
    while (avs_waitrequest && waits < 10) begin
      waits++; @(posedge clk); #2;
    end
    rd = avs_readdata;
    @(posedge clk); #1;
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (MonDReg !== 32'h0) begin n_fail++; $display("FAIL reset_mondreg got %h want 0", MonDReg); end
    n_checks++; if (monitor_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", monitor_ready); end
    n_checks++; if (monitor_error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", monitor_error); end
    n_checks++; if (avs_readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata got %h want 0", avs_readdata); end
    n_checks++; if (avs_waitrequest !== 1'b0) begin n_fail++; $display("FAIL reset_waitreq got %b want 0", avs_waitrequest); end
  endtask

  task automatic test_jtag_wr_rd();
    logic [31:0] e;
    jtag_a(8'h10, 1'b0);
    jtag_b(32'hDEADBEEF);
    model[8'h10] = 32'hDEADBEEF;
    jexp.push_back(model[8'h10]);
    jtag_a(8'h10, 1'b1);
    n_checks++; if (monitor_ready !== 1'b0) begin n_fail++; $display("FAIL wrrd_ready_n1 got %b want 0", monitor_ready); end
    tick();
    n_checks++; if (monitor_ready !== 1'b0) begin n_fail++; $display("FAIL wrrd_ready_n2 got %b want 0", monitor_ready); end
    tick();
    e = jexp.pop_front();
    n_checks++; if (monitor_ready !== 1'b1 || MonDReg !== e) begin
      n_fail++; $display("FAIL wrrd_n3 got ready=%b data=%h want ready=1 data=%h", monitor_ready, MonDReg, e);
    end
    n_checks++; if (monitor_error !== 1'b0) begin n_fail++; $display("FAIL wrrd_error got %b want 0", monitor_error); end
  endtask

  task automatic test_stream_wrap();
    logic [7:0]  a;
    logic [31:0] e;
    logic        ok;
    jtag_a(8'hFF, 1'b0);
    a = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      jtag_b(32'h1000_0000 + 32'(k) * 32'h0101_0101);
      model[a] = 32'h1000_0000 + 32'(k) * 32'h0101_0101;
      a = a + 8'd1;
      tick(); tick();
    end
    jtag_a(8'hFF, 1'b0);
    a = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      jexp.push_back(model[a]);
      a = a + 8'd1;
      jtag_n();
      wait_ready(ok);
      e = jexp.pop_front();
      n_checks++; if (!ok || MonDReg !== e) begin
        n_fail++; $display("FAIL stream_rd%0d got ok=%b data=%h want %h", k, ok, MonDReg, e);
      end
    end
  endtask

  task automatic test_cpu();
    logic [31:0] rd, e;
    int          w;
    jtag_a(8'h20, 1'b0);
    jtag_b(32'hAAAAAAAA);
    tick(); tick();
    cpu_xfer(1'b1, 8'h20, 32'h12345678, 4'b0011, 1'b1, rd, w);
    n_checks++; if (w !== 1) begin n_fail++; $display("FAIL cpu_wr_waits got %0d want 1", w); end
    cexp.push_back(32'hAAAA5678);
    cpu_xfer(1'b0, 8'h20, 32'h0, 4'hF, 1'b0, rd, w);
    e = cexp.pop_front();
    n_checks++; if (rd !== e) begin n_fail++; $display("FAIL cpu_rd_be got %h want %h", rd, e); end
    n_checks++; if (w !== 1) begin n_fail++; $display("FAIL cpu_rd_waits got %0d want 1", w); end
    cpu_xfer(1'b1, 8'h20, 32'h12345678, 4'b0011, 1'b0, rd, w);
    cpu_xfer(1'b1, 8'h20, 32'hFFFFFFFF, 4'b1111, 1'b0, rd, w);
    cexp.push_back(32'hAAAA5678);
    cpu_xfer(1'b0, 8'h20, 32'h0, 4'hF, 1'b0, rd, w);
    e = cexp.pop_front();
    n_checks++; if (rd !== e) begin n_fail++; $display("FAIL cpu_nodbg got %h want %h", rd, e); end
  endtask

  task automatic test_contention();
    logic [31:0] rd, e;
    int          w;
    jtag_a(8'h30, 1'b0);
    jdo = '0; jdo[34:3] = 32'hC0FFEE11;
    take_b = 1'b1; tick(); take_b = 1'b0;
    cexp.push_back(32'hC0FFEE11);
    cpu_xfer(1'b0, 8'h30, 32'h0, 4'hF, 1'b0, rd, w);
    e = cexp.pop_front();
    n_checks++; if (rd !== e) begin n_fail++; $display("FAIL contention_data got %h want %h", rd, e); end
    n_checks++; if (w !== 2) begin n_fail++; $display("FAIL contention_waits got %0d want 2", w); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] e;
    logic        ok;
    jtag_a(8'h40, 1'b0);
    jtag_b(32'h55AA33CC);
    tick(); tick();
    jdo = '0; jdo[34] = 1'b1; jdo[24:17] = 8'h40;
    take_a = 1'b1; take_b = 1'b1; tick(); take_a = 1'b0; take_b = 1'b0;
    jexp.push_back(32'h55AA33CC);
    wait_ready(ok);
    e = jexp.pop_front();
    n_checks++; if (!ok || MonDReg !== e) begin n_fail++; $display("FAIL simul_rd got ok=%b data=%h want %h", ok, MonDReg, e); end
    n_checks++; if (monitor_error !== 1'b1) begin n_fail++; $display("FAIL simul_error got %b want 1", monitor_error); end
    jexp.push_back(32'h55AA33CC);
    jtag_n();
    wait_ready(ok);
    e = jexp.pop_front();
    n_checks++; if (!ok || MonDReg !== e) begin n_fail++; $display("FAIL simul_b_dropped got ok=%b data=%h want %h", ok, MonDReg, e); end
    do_reset();
  endtask

  task automatic test_overrun();
    logic [31:0] e;
    logic        ok;
    n_checks++; if (monitor_error !== 1'b0) begin n_fail++; $display("FAIL ovr_start got %b want 0", monitor_error); end
    jtag_a(8'hFF, 1'b0);
    jexp.push_back(model[8'hFF]);
    take_n = 1'b1; tick(); tick(); take_n = 1'b0;
    wait_ready(ok);
    e = jexp.pop_front();
    n_checks++; if (!ok || MonDReg !== e) begin n_fail++; $display("FAIL ovr_rd got ok=%b data=%h want %h", ok, MonDReg, e); end
    repeat (4) tick();
    n_checks++; if (monitor_error !== 1'b1) begin n_fail++; $display("FAIL ovr_error got %b want 1", monitor_error); end
    jexp.push_back(model[8'h00]);
    jtag_n();
    wait_ready(ok);
    e = jexp.pop_front();
    n_checks++; if (!ok || MonDReg !== e) begin n_fail++; $display("FAIL ovr_single_inc got ok=%b data=%h want %h", ok, MonDReg, e); end
    n_checks++; if (monitor_error !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got %b want 1", monitor_error); end
    do_reset();
    n_checks++; if (monitor_error !== 1'b0) begin n_fail++; $display("FAIL ovr_reset_clear got %b want 0", monitor_error); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    test_reset();
    test_jtag_wr_rd();
    test_stream_wrap();
    test_cpu();
    test_contention();
    test_simultaneous();
    test_overrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
